// File: rtl/ct_fcnvt_stoh_seq.sv
// ct_fcnvt_stoh_seq
// Four-lane FP32 -> FP16 conversion sequencer for the vector FP convert unit.
// A request of four FP32 elements is latched and classified in one cycle:
// normal, special and zero lanes are converted in parallel. Lanes whose FP16
// result is subnormal (or underflows) are issued one per cycle, lowest lane
// first, to the shared external single-to-half denormal shifter. Its outputs
// come back in the same cycle and are rounded to nearest-even here. The packed
// result and the accumulated flags are then returned under valid/ready.
//
// Ports
//   forever_cpuclk   clock, all state on the rising edge
//   cpurst           synchronous active-high reset
//   stoh_flush       kill any in-flight operation, return to idle
//   stoh_in_vld/rdy  request handshake
//   stoh_in_src      lane i = [32i+31:32i], FP32
//   stoh_in_lane_en  per-lane enable; disabled lanes return 0 with no flags
//   stoh_sh_cnt      to shifter: FP32 biased exponent of the issued lane
//   stoh_sh_src      to shifter: FP32 fraction of the issued lane
//   stoh_sh_f_v      from shifter: kept bits
//   stoh_sh_f_x      from shifter: shifted-out bits, guard at bit 24
//   stoh_out_vld/rdy result handshake
//   stoh_out_data    lane i = [16i+15:16i], FP16
//   stoh_out_fflags  {NV,DZ,OF,UF,NX}, OR over enabled lanes
module ct_fcnvt_stoh_seq (
  input  logic         forever_cpuclk,
  input  logic         cpurst,
  input  logic         stoh_flush,
  input  logic         stoh_in_vld,
  output logic         stoh_in_rdy,
  input  logic [127:0] stoh_in_src,
  input  logic [3:0]   stoh_in_lane_en,
  output logic [7:0]   stoh_sh_cnt,
  output logic [22:0]  stoh_sh_src,
  input  logic [10:0]  stoh_sh_f_v,
  input  logic [24:0]  stoh_sh_f_x,
  output logic         stoh_out_vld,
  input  logic         stoh_out_rdy,
  output logic [63:0]  stoh_out_data,
  output logic [4:0]   stoh_out_fflags
);

  localparam int unsigned F_NV = 4;
  localparam int unsigned F_OF = 2;
  localparam int unsigned F_UF = 1;
  localparam int unsigned F_NX = 0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state_q, state_d;

  // Latched request and result state
  logic [3:0]       sign_q;
  logic [3:0][7:0]  exp_q;
  logic [3:0][22:0] frac_q;
  logic [3:0][15:0] res_q;
  logic [4:0]       flags_q;
  logic [3:0]       sub_mask_q;
  logic             hold_q;

  // Field split of the incoming request
  logic [3:0]       in_s;
  logic [3:0][7:0]  in_e;
  logic [3:0][22:0] in_m;

  // Classification of the incoming request
  logic [3:0][4:0]  nrm_exp;
  logic [3:0]       nrm_inc;
  logic [3:0][14:0] nrm_mag;
  logic [3:0][15:0] cls_res;
  logic [3:0][4:0]  cls_flags;
  logic [3:0]       cls_sub;
  logic [4:0]       cls_acc;

  // Shifter issue and rounding
  logic [1:0]       sel;
  logic             sel_found;
  logic [3:0]       mask_rest;
  logic             sh_g;
  logic             sh_st;
  logic             sh_inc;
  logic             sub_nx;
  logic [14:0]      sub_mag;

  logic             accept;

  always_comb begin
    in_s = '0;
    in_e = '0;
    in_m = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      in_s[i] = stoh_in_src[32*i+31];
      in_e[i] = stoh_in_src[32*i+23 +: 8];
      in_m[i] = stoh_in_src[32*i +: 23];
    end
  end

  always_comb begin
    nrm_exp   = '0;
    nrm_inc   = '0;
    nrm_mag   = '0;
    cls_res   = '0;
    cls_flags = '0;
    cls_sub   = '0;
    cls_acc   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      // Rebias 127 -> 15 is e - 0x70; only the low five bits survive in the
      // normal range, so subtract modulo 32 on the low bits directly.
      nrm_exp[i] = in_e[i][4:0] - 5'h10;
      nrm_inc[i] = in_m[i][12] & ((|in_m[i][11:0]) | in_m[i][13]);
      // A rounding carry out of the fraction bumps the exponent; at the top
      // binade this lands exactly on the infinity encoding.
      nrm_mag[i] = {nrm_exp[i], in_m[i][22:13]} + {14'd0, nrm_inc[i]};

      if (stoh_in_lane_en[i]) begin
        if (in_e[i] == 8'hFF) begin
          if (|in_m[i]) begin
            cls_res[i]         = 16'h7E00;
            cls_flags[i][F_NV] = ~in_m[i][22];
          end else begin
            cls_res[i] = {in_s[i], 15'h7C00};
          end
        end else if (in_e[i] == 8'h00) begin
          cls_res[i] = {in_s[i], 15'h0000};
        end else if (in_e[i] >= 8'h8F) begin
          cls_res[i]         = {in_s[i], 15'h7C00};
          cls_flags[i][F_OF] = 1'b1;
          cls_flags[i][F_NX] = 1'b1;
        end else if (in_e[i] >= 8'h71) begin
          cls_res[i]         = {in_s[i], nrm_mag[i]};
          cls_flags[i][F_OF] = (nrm_mag[i] == 15'h7C00);
          cls_flags[i][F_NX] = |in_m[i][12:0];
        end else begin
          cls_sub[i] = 1'b1;
        end
      end
      cls_acc = cls_acc | cls_flags[i];
    end
  end

  // Lowest pending subnormal lane is issued this cycle
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sub_mask_q[i] && !sel_found) begin
        sel       = 2'(i);
        sel_found = 1'b1;
      end
    end
    mask_rest = sub_mask_q & ~(4'b0001 << sel);
  end

  assign sh_g    = stoh_sh_f_x[24];
  assign sh_st   = |stoh_sh_f_x[23:0];
  assign sh_inc  = sh_g & (sh_st | stoh_sh_f_v[0]);
  assign sub_nx  = sh_g | sh_st;
  // Kept bits sit directly in the FP16 fraction field with a zero exponent;
  // a carry out of the fraction yields the smallest normal 0x0400.
  assign sub_mag = {4'd0, stoh_sh_f_v} + {14'd0, sh_inc};

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    stoh_in_rdy  = 1'b0;
    stoh_out_vld = 1'b0;
    stoh_sh_cnt  = '0;
    stoh_sh_src  = '0;
    case (state_q)
      IDLE: begin
        stoh_in_rdy = ~hold_q;
        accept      = stoh_in_vld & ~hold_q & ~stoh_flush;
        if (accept) begin
          state_d = (|cls_sub) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        stoh_sh_cnt = exp_q[sel];
        stoh_sh_src = frac_q[sel];
        if (mask_rest == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        stoh_out_vld = 1'b1;
        if (stoh_out_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (stoh_flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q    <= IDLE;
      sign_q     <= '0;
      exp_q      <= '0;
      frac_q     <= '0;
      res_q      <= '0;
      flags_q    <= '0;
      sub_mask_q <= '0;
      hold_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (stoh_flush) begin
        sub_mask_q <= '0;
        hold_q     <= 1'b0;
      end else begin
        // One idle turnaround cycle after a result is taken gives the
        // three-cycle minimum initiation interval.
        hold_q <= (state_q == DONE) & stoh_out_rdy;
        if (accept) begin
          sign_q     <= in_s;
          exp_q      <= in_e;
          frac_q     <= in_m;
          res_q      <= cls_res;
          flags_q    <= cls_acc;
          sub_mask_q <= cls_sub;
        end else if (state_q == SHIFT) begin
          res_q[sel] <= {sign_q[sel], sub_mag};
          flags_q    <= flags_q | {3'b000, sub_nx, sub_nx};
          sub_mask_q <= mask_rest;
        end
      end
    end
  end

  assign stoh_out_data   = res_q;
  assign stoh_out_fflags = flags_q;

endmodule

// File: tb/tb_ct_fcnvt_stoh_seq.sv
// Testbench for ct_fcnvt_stoh_seq. Models the external denormal shifter,
// applies a table of conversion vectors with a result scoreboard, then runs
// backpressure, flush and reset sequences.
module tb_ct_fcnvt_stoh_seq;

  logic         clk = 1'b0;
  logic         cpurst;
  logic         stoh_flush;
  logic         stoh_in_vld;
  logic         stoh_in_rdy;
  logic [127:0] stoh_in_src;
  logic [3:0]   stoh_in_lane_en;
  logic [7:0]   stoh_sh_cnt;
  logic [22:0]  stoh_sh_src;
  logic [10:0]  stoh_sh_f_v;
  logic [24:0]  stoh_sh_f_x;
  logic         stoh_out_vld;
  logic         stoh_out_rdy;
  logic [63:0]  stoh_out_data;
  logic [4:0]   stoh_out_fflags;

  always #5 clk = ~clk;

  ct_fcnvt_stoh_seq dut (
    .forever_cpuclk  (clk),
    .cpurst          (cpurst),
    .stoh_flush      (stoh_flush),
    .stoh_in_vld     (stoh_in_vld),
    .stoh_in_rdy     (stoh_in_rdy),
    .stoh_in_src     (stoh_in_src),
    .stoh_in_lane_en (stoh_in_lane_en),
    .stoh_sh_cnt     (stoh_sh_cnt),
    .stoh_sh_src     (stoh_sh_src),
    .stoh_sh_f_v     (stoh_sh_f_v),
    .stoh_sh_f_x     (stoh_sh_f_x),
    .stoh_out_vld    (stoh_out_vld),
    .stoh_out_rdy    (stoh_out_rdy),
    .stoh_out_data   (stoh_out_data),
    .stoh_out_fflags (stoh_out_fflags)
  );

  // Shifter: value in units of 2^-24 is {1,m} >> (126-e); kept bits in f_v,
  // the shifted-out bits left-aligned in f_x (guard at bit 24).
  function automatic logic [35:0] shmodel(input logic [7:0] e, input logic [22:0] m);
    int          sh;
    logic [48:0] w;
    sh = 126 - int'(e);
    if (sh < 0) sh = 0;
    w = {1'b1, m, 25'd0};
    if (sh <= 25) begin
      w = w >> sh;
      return {w[35:25], w[24:0]};
    end
    return {11'd0, 25'd1};
  endfunction

  assign {stoh_sh_f_v, stoh_sh_f_x} = shmodel(stoh_sh_cnt, stoh_sh_src);

  typedef struct {
    logic [127:0] src;
    logic [3:0]   en;
    logic [63:0]  data;
    logic [4:0]   flags;
    int           n;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  flags;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Scoreboard: one expected result per accepted request, popped on handshake
  always @(negedge clk) begin
    if (stoh_out_vld && stoh_out_rdy) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got data %0h, required no result", stoh_out_data);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_data", stoh_out_data, mon_e.data);
        chk("sb_flags", {59'd0, stoh_out_fflags}, {59'd0, mon_e.flags});
      end
    end
  end

  task automatic wait_in_rdy(input string name, output bit ok);
    int wc = 0;
    @(negedge clk);
    while (!stoh_in_rdy && wc < 20) begin
      @(negedge clk);
      wc++;
    end
    ok = stoh_in_rdy;
    chk(name, {63'd0, ok}, 64'd1);
  endtask

  task automatic send(input int idx, input int hold);
    vec_t        v;
    bit          ok;
    logic [31:0] w;
    logic [7:0]  le[$];
    logic [22:0] lm[$];
    v = vecs[idx];
    for (int i = 0; i < 4; i++) begin
      w = v.src[32*i +: 32];
      if (v.en[i] && w[30:23] >= 8'h01 && w[30:23] <= 8'h70) begin
        le.push_back(w[30:23]);
        lm.push_back(w[22:0]);
      end
    end
    @(posedge clk); #1;
    stoh_in_src     = v.src;
    stoh_in_lane_en = v.en;
    stoh_in_vld     = 1'b1;
    stoh_out_rdy    = (hold == 0);
    wait_in_rdy($sformatf("v%0d_accept", idx), ok);
    if (!ok) begin
      stoh_in_vld  = 1'b0;
      stoh_out_rdy = 1'b1;
      return;
    end
    sb.push_back('{data: v.data, flags: v.flags});
    @(posedge clk); #1;
    stoh_in_vld = 1'b0;
    for (int k = 0; k < v.n; k++) begin
      @(negedge clk);
      chk($sformatf("v%0d_shift%0d_vld", idx, k), {63'd0, stoh_out_vld}, 64'd0);
      chk($sformatf("v%0d_shift%0d_cnt", idx, k), {56'd0, stoh_sh_cnt}, {56'd0, le[k]});
      chk($sformatf("v%0d_shift%0d_src", idx, k), {41'd0, stoh_sh_src}, {41'd0, lm[k]});
      chk($sformatf("v%0d_shift%0d_inrdy", idx, k), {63'd0, stoh_in_rdy}, 64'd0);
    end
    @(negedge clk);
    chk($sformatf("v%0d_latency_vld", idx), {63'd0, stoh_out_vld}, 64'd1);
    chk($sformatf("v%0d_done_shcnt", idx), {56'd0, stoh_sh_cnt}, 64'd0);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        chk($sformatf("v%0d_hold%0d_vld", idx, h), {63'd0, stoh_out_vld}, 64'd1);
        chk($sformatf("v%0d_hold%0d_data", idx, h), stoh_out_data, v.data);
        chk($sformatf("v%0d_hold%0d_inrdy", idx, h), {63'd0, stoh_in_rdy}, 64'd0);
        @(negedge clk);
      end
      @(posedge clk); #1;
      stoh_out_rdy = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    chk($sformatf("v%0d_turnaround_inrdy", idx), {63'd0, stoh_in_rdy}, 64'd0);
    @(negedge clk);
    chk($sformatf("v%0d_ii_inrdy", idx), {63'd0, stoh_in_rdy}, 64'd1);
  endtask

  // Kill a four-subnormal request on its second SHIFT cycle
  task automatic kill_midshift(input bit use_rst);
    bit    ok;
    bit    seen;
    string tag;
    tag = use_rst ? "rst" : "flush";
    @(posedge clk); #1;
    stoh_in_src     = vecs[1].src;
    stoh_in_lane_en = vecs[1].en;
    stoh_in_vld     = 1'b1;
    stoh_out_rdy    = 1'b1;
    wait_in_rdy({tag, "_accept"}, ok);
    @(posedge clk); #1;
    stoh_in_vld = 1'b0;
    if (!ok) return;
    @(negedge clk);
    chk({tag, "_shift1_cnt"}, {56'd0, stoh_sh_cnt}, 64'h67);
    @(posedge clk); #1;
    if (use_rst) cpurst = 1'b1;
    else stoh_flush = 1'b1;
    @(negedge clk);
    chk({tag, "_shift2_cnt"}, {56'd0, stoh_sh_cnt}, 64'h67);
    @(posedge clk); #1;
    cpurst     = 1'b0;
    stoh_flush = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_inrdy"}, {63'd0, stoh_in_rdy}, 64'd1);
    chk({tag, "_idle_vld"}, {63'd0, stoh_out_vld}, 64'd0);
    chk({tag, "_idle_shcnt"}, {56'd0, stoh_sh_cnt}, 64'd0);
    if (use_rst) begin
      chk("rst_data", stoh_out_data, 64'd0);
      chk("rst_flags", {59'd0, stoh_out_fflags}, 64'd0);
      chk("rst_shsrc", {41'd0, stoh_sh_src}, 64'd0);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (stoh_out_vld) seen = 1'b1;
    end
    chk({tag, "_vld_never_rises"}, {63'd0, seen}, 64'd0);
    if (!use_rst) begin
      // Flush in the same cycle as a request in IDLE: nothing is accepted
      @(posedge clk); #1;
      stoh_in_src     = vecs[0].src;
      stoh_in_lane_en = vecs[0].en;
      stoh_in_vld     = 1'b1;
      stoh_flush      = 1'b1;
      @(posedge clk); #1;
      stoh_in_vld = 1'b0;
      stoh_flush  = 1'b0;
      @(negedge clk);
      chk("flush_beats_req_vld", {63'd0, stoh_out_vld}, 64'd0);
      chk("flush_beats_req_inrdy", {63'd0, stoh_in_rdy}, 64'd1);
    end
    send(1, 0);
  endtask

  initial begin
    vecs[0] = '{src: {32'h38800000, 32'h477FE000, 32'hBF800000, 32'h3F800000}, en: 4'hF,
                data: {16'h0400, 16'h7BFF, 16'hBC00, 16'h3C00}, flags: 5'b00000, n: 0};
    vecs[1] = '{src: {32'h33800001, 32'h33800001, 32'h33800001, 32'h33800001}, en: 4'hF,
                data: {16'h0001, 16'h0001, 16'h0001, 16'h0001}, flags: 5'b00011, n: 4};
    vecs[2] = '{src: {32'h387FE000, 32'hB3400000, 32'h33400000, 32'h33000000}, en: 4'hF,
                data: {16'h0400, 16'h8001, 16'h0001, 16'h0000}, flags: 5'b00011, n: 4};
    vecs[3] = '{src: {32'h47800000, 32'hFF800000, 32'h7F800001, 32'h7FC00000}, en: 4'hF,
                data: {16'h7C00, 16'hFC00, 16'h7E00, 16'h7E00}, flags: 5'b10101, n: 0};
    vecs[4] = '{src: {32'h80000001, 32'h3F803000, 32'h3F801000, 32'h477FF000}, en: 4'hF,
                data: {16'h8000, 16'h3C02, 16'h3C00, 16'h7C00}, flags: 5'b00101, n: 0};
    vecs[5] = '{src: {32'hC7800000, 32'h3F800000, 32'h80000000, 32'h38000000}, en: 4'b1011,
                data: {16'hFC00, 16'h0000, 16'h8000, 16'h0200}, flags: 5'b00101, n: 1};
    vecs[6] = '{src: {32'h33800001, 32'h33800001, 32'h33800001, 32'h33800001}, en: 4'b0101,
                data: {16'h0000, 16'h0001, 16'h0000, 16'h0001}, flags: 5'b00011, n: 2};

    cpurst          = 1'b1;
    stoh_flush      = 1'b0;
    stoh_in_vld     = 1'b0;
    stoh_in_src     = '0;
    stoh_in_lane_en = '0;
    stoh_out_rdy    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cpurst = 1'b0;
    @(negedge clk);
    chk("reset_inrdy", {63'd0, stoh_in_rdy}, 64'd1);
    chk("reset_vld", {63'd0, stoh_out_vld}, 64'd0);
    chk("reset_data", stoh_out_data, 64'd0);
    chk("reset_flags", {59'd0, stoh_out_fflags}, 64'd0);
    chk("reset_shcnt", {56'd0, stoh_sh_cnt}, 64'd0);
    chk("reset_shsrc", {41'd0, stoh_sh_src}, 64'd0);

    for (int i = 0; i < 6; i++) send(i, 0);
    send(6, 10);
    kill_midshift(1'b0);
    kill_midshift(1'b1);

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
